// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with start/busy/done handshake, iterative radix-2^RADIX_BITS MUL/DIV
// and zero/carry/div-by-zero/illegal flags; opcodes follow the core's cmd_codes encoding.
module alu_seq #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_oe,
  input  logic             start,
  input  logic [3:0]       cmd_code,
  input  logic [WIDTH-1:0] src0_in,
  input  logic [WIDTH-1:0] src1_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dst_out,
  output logic [WIDTH-1:0] dst_h_out,
  output logic [WIDTH-1:0] src0_out,
  output logic [WIDTH-1:0] src1_out,
  output logic             zero,
  output logic             carry,
  output logic             div_zero,
  output logic             illegal
);
  localparam int W  = WIDTH;
  localparam int R  = RADIX_BITS;
  localparam int N  = W / R;
  localparam int CW = $clog2(N + 1);
  localparam logic [3:0] CMD_MOV = 4'd0, CMD_ADD = 4'd1, CMD_SUB = 4'd2, CMD_MUL = 4'd3,
                         CMD_DIV = 4'd4, CMD_SHL = 4'd5, CMD_SHR = 4'd6, CMD_XOR = 4'd7,
                         CMD_AND = 4'd8, CMD_OR  = 4'd9;
  typedef enum logic [1:0] {IDLE, ONE, ITER, FIN} state_t;
  state_t         state_q;
  logic [3:0]     op_q;
  logic [W-1:0]   a_q, b_q;
  logic [2*W-1:0] p_q, p_d, res_d, za, zb;
  logic [CW-1:0]  cnt_q;
  logic [W+R-1:0] sum;
  logic [W:0]     t;
  logic [W-1:0]   rem, quo;
  logic           carry_d;
  assign za = {{W{1'b0}}, a_q};
  assign zb = {{W{1'b0}}, b_q};
  // p_q holds {acc, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    sum = {{R{1'b0}}, p_q[2*W-1:W]} + ({{R{1'b0}}, a_q} * {{W{1'b0}}, p_q[R-1:0]});
    rem = p_q[2*W-1:W];
    quo = p_q[W-1:0];
    t   = '0;
    for (int i = 0; i < R; i++) begin
      t   = {rem, quo[W-1]};
      quo = {quo[W-2:0], t >= {1'b0, b_q}};
      rem = quo[0] ? W'(t - {1'b0, b_q}) : t[W-1:0];
    end
    p_d = op_q == CMD_MUL ? {sum, p_q[W-1:R]} : {rem, quo};
  end
  always_comb begin
    res_d = op_q == CMD_MOV ? za :
            op_q == CMD_ADD ? za + zb :
            op_q == CMD_SUB ? za - zb :
            op_q == CMD_SHL ? {{W{1'b0}}, a_q << b_q} :
            op_q == CMD_SHR ? {{W{1'b0}}, a_q >> b_q} :
            op_q == CMD_XOR ? za ^ zb :
            op_q == CMD_AND ? za & zb :
            op_q == CMD_OR  ? za | zb :
            op_q == CMD_DIV ? {a_q, {W{1'b1}}} : '0;
    carry_d = op_q == CMD_ADD ? res_d[W] : op_q == CMD_SUB ? a_q < b_q : 1'b0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      {op_q, a_q, b_q, p_q, cnt_q} <= '0;
      {busy, done, zero, carry, div_zero, illegal} <= '0;
      {dst_out, dst_h_out, src0_out, src1_out} <= '0;
    end else if (clk_oe) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= (cmd_code == CMD_MUL || (cmd_code == CMD_DIV && src1_in != '0)) ? ITER : ONE;
            op_q    <= cmd_code;
            a_q     <= src0_in;
            b_q     <= src1_in;
            p_q     <= {{W{1'b0}}, cmd_code == CMD_MUL ? src1_in : src0_in};
            cnt_q   <= CW'(N);
            busy    <= 1'b1;
            {done, zero, carry, div_zero, illegal} <= '0;
          end else begin
            busy <= 1'b0;
            done <= 1'b0;
          end
        end
        ONE: begin
          {dst_h_out, dst_out} <= res_d;
          src0_out <= op_q == CMD_MOV ? b_q : a_q;
          src1_out <= op_q == CMD_MOV ? a_q : b_q;
          zero     <= res_d == '0;
          carry    <= carry_d;
          div_zero <= op_q == CMD_DIV;
          illegal  <= op_q > CMD_OR;
          done     <= 1'b1;
          state_q  <= IDLE;
        end
        ITER: begin
          p_q   <= p_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= FIN;
        end
        FIN: begin
          {dst_h_out, dst_out} <= p_q;
          src0_out <= a_q;
          src1_out <= b_q;
          zero     <= p_q == '0;
          done     <= 1'b1;
          state_q  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq; a driver queues expected results, a monitor checks them on done.
module tb_alu_seq;
  localparam logic [3:0] C_MOV = 4'd0, C_ADD = 4'd1, C_SUB = 4'd2, C_MUL = 4'd3, C_DIV = 4'd4,
                         C_SHL = 4'd5, C_SHR = 4'd6, C_XOR = 4'd7, C_AND = 4'd8, C_OR = 4'd9;
  logic clk = 0, rst = 1, clk_oe = 1, start = 0, start4 = 0, oe_mode = 0, done_seen = 0;
  logic [3:0] cmd = 0;
  logic [31:0] s0 = 0, s1 = 0;
  logic busy, done, zero, carry, div_zero, illegal;
  logic [31:0] dst, dst_h, s0o, s1o;
  logic busy4, done4, zero4, carry4, div_zero4, illegal4;
  logic [31:0] dst4, dst_h4, s0o4, s1o4;
  int total = 0, passed = 0, en_edges = 0;
  typedef struct {logic [31:0] lo, hi, s0, s1; logic [3:0] fl; int lat; int acc;} exp_t;
  exp_t q[$];

  alu_seq #(.WIDTH(32), .RADIX_BITS(1)) dut (
    .clk(clk), .rst(rst), .clk_oe(clk_oe), .start(start), .cmd_code(cmd), .src0_in(s0), .src1_in(s1),
    .busy(busy), .done(done), .dst_out(dst), .dst_h_out(dst_h), .src0_out(s0o), .src1_out(s1o),
    .zero(zero), .carry(carry), .div_zero(div_zero), .illegal(illegal));

  alu_seq #(.WIDTH(32), .RADIX_BITS(4)) dut4 (
    .clk(clk), .rst(rst), .clk_oe(1'b1), .start(start4), .cmd_code(cmd), .src0_in(s0), .src1_in(s1),
    .busy(busy4), .done(done4), .dst_out(dst4), .dst_h_out(dst_h4), .src0_out(s0o4), .src1_out(s1o4),
    .zero(zero4), .carry(carry4), .div_zero(div_zero4), .illegal(illegal4));

  always #5 clk = ~clk;
  always @(posedge clk) if (clk_oe) en_edges <= en_edges + 1;
  initial forever begin
    @(negedge clk);
    clk_oe = oe_mode ? !clk_oe : 1'b1;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // waits for IDLE, holds start until an enabled edge accepts it, then queues the expectation
  task automatic run(input logic [3:0] c, input logic [31:0] a, b, lo, hi, input logic [3:0] fl, input int lat);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (busy && !done && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin total++; $display("FAIL idle_wait: busy stuck at %0b, expected 0", busy); end
    cmd = c; s0 = a; s1 = b; start = 1; n = 0;
    do begin @(posedge clk); #1; n++; end while (!clk_oe && n < 10);
    start = 0;
    e.lo = lo; e.hi = hi; e.fl = fl; e.lat = lat; e.acc = en_edges;
    e.s0 = c == C_MOV ? b : a;
    e.s1 = c == C_MOV ? a : b;
    q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    chk("queue_drained", 64'(q.size()), 64'd0);
  endtask

  task automatic r4(input logic [3:0] c, input logic [31:0] a, b, lo, hi, input int lat);
    int n = 0;
    @(negedge clk);
    cmd = c; s0 = a; s1 = b; start4 = 1;
    @(posedge clk); #1;
    start4 = 0;
    do begin @(posedge clk); #1; n++; end while (!done4 && n < 60);
    chk("r4_latency", 64'(n), 64'(lat));
    chk("r4_dst", 64'(dst4), 64'(lo));
    chk("r4_dst_h", 64'(dst_h4), 64'(hi));
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_dst"}, 64'(dst), 64'd0);
    chk({tag, "_dst_h"}, 64'(dst_h), 64'd0);
    chk({tag, "_src0_out"}, 64'(s0o), 64'd0);
    chk({tag, "_src1_out"}, 64'(s1o), 64'd0);
    chk({tag, "_flags"}, 64'({zero, carry, div_zero, illegal}), 64'd0);
  endtask

  initial forever begin
    @(negedge clk);
    if (rst && done && !done_seen) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: done=%0b with nothing outstanding, expected 0", done);
      end else begin
        chk("dst", 64'(dst), 64'(q[0].lo));
        chk("dst_h", 64'(dst_h), 64'(q[0].hi));
        chk("src0_out", 64'(s0o), 64'(q[0].s0));
        chk("src1_out", 64'(s1o), 64'(q[0].s1));
        chk("flags_zcdi", 64'({zero, carry, div_zero, illegal}), 64'(q[0].fl));
        chk("latency", 64'(en_edges - q[0].acc), 64'(q[0].lat));
        chk("busy_at_done", 64'(busy), 64'd1);
        void'(q.pop_front());
      end
    end
    done_seen = done;
  end

  initial begin
    int acc, n;
    #2 rst = 0;
    #10 chk_cleared("reset");
    @(negedge clk) rst = 1;
    run(C_ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h1, 4'b0100, 1);
    run(C_SUB, 32'd5, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFF, 4'b0100, 1);
    run(C_SUB, 32'd7, 32'd5, 32'd2, 32'd0, 4'b0000, 1);
    run(C_ADD, 32'd0, 32'd0, 32'd0, 32'd0, 4'b1000, 1);
    run(C_MOV, 32'h11, 32'h22, 32'h11, 32'h0, 4'b0000, 1);
    run(C_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 4'b0000, 33);
    repeat (5) begin
      @(negedge clk) cmd = C_ADD; s0 = 32'd1; s1 = 32'd2; start = 1;
      @(negedge clk) start = 0;
    end
    run(C_DIV, 32'd100, 32'd7, 32'd14, 32'd2, 4'b0000, 33);
    run(C_DIV, 32'd7, 32'd100, 32'd0, 32'd7, 4'b0000, 33);
    run(C_DIV, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9, 4'b0010, 1);
    run(C_SHL, 32'd1, 32'd40, 32'd0, 32'd0, 4'b1000, 1);
    run(C_SHL, 32'd3, 32'd4, 32'h30, 32'd0, 4'b0000, 1);
    run(C_SHR, 32'h80000000, 32'd31, 32'd1, 32'd0, 4'b0000, 1);
    run(C_XOR, 32'hF0F0, 32'h0FF0, 32'hFF00, 32'd0, 4'b0000, 1);
    run(C_AND, 32'hF0F0, 32'h0FF0, 32'h00F0, 32'd0, 4'b0000, 1);
    run(C_OR, 32'hF0F0, 32'h0FF0, 32'hFFF0, 32'd0, 4'b0000, 1);
    run(4'hC, 32'd5, 32'd6, 32'd0, 32'd0, 4'b1001, 1);
    drain();
    oe_mode = 1;
    run(C_MUL, 32'h10000, 32'h10000, 32'h0, 32'h1, 4'b0000, 33);
    run(C_ADD, 32'd2, 32'd3, 32'd5, 32'd0, 4'b0000, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 20);
    @(posedge clk); #1 chk("done_stretch", 64'(done), 64'd1);
    @(posedge clk); #1 chk("done_clear", 64'(done), 64'd0);
    drain();
    oe_mode = 0;
    run(C_MUL, 32'd3, 32'd5, 32'd15, 32'd0, 4'b0000, 33);
    acc = q[$].acc; n = 0;
    while (en_edges - acc < 10 && n < 50) begin @(posedge clk); #1; n++; end
    #2 rst = 0;
    #1 chk_cleared("abort");
    q.delete();
    @(negedge clk) rst = 1;
    repeat (40) @(negedge clk);
    chk("busy_after_abort", 64'(busy), 64'd0);
    run(C_ADD, 32'd1, 32'd1, 32'd2, 32'd0, 4'b0000, 1);
    drain();
    r4(C_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 9);
    r4(C_DIV, 32'd100, 32'd7, 32'd14, 32'd2, 9);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
